// File: rtl/tinker_fetch_queue.sv
// Instruction prefetch queue: issues sequential 32-bit reads (one outstanding at a time)
// and buffers {pc, word} pairs in an in-order FIFO for the decoder.
module tinker_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [63:0]              imem_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  input  logic                     halt,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [63:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid && ready are both high at the
  // rising edge; valid never depends on ready. imem_resp_valid has no ready (always accepted).

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic [63:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic req_fire;
  logic push;
  logic pop;

  // Space is reserved at issue time, so a returning word always has a slot.
  assign imem_req_valid = !reset && (state_q == ST_RUN) && !halt && (count_q < DEPTH_C);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop            = inst_valid && inst_ready && !redirect_valid;

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 64'd0;
  assign count      = count_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      ST_RUN:  if (req_fire) state_d = ST_WAIT;
      ST_WAIT: if (imem_resp_valid) state_d = ST_RUN;
      ST_DROP: if (imem_resp_valid) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (req_fire) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW + 1)'(1);
    else if (pop && !push) count_d = count_q - (PW + 1)'(1);

    // A redirect wins over everything: flush, retarget, and mark any in-flight read stale.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (state_q == ST_RUN) state_d = req_fire ? ST_DROP : ST_RUN;
      else                   state_d = imem_resp_valid ? ST_RUN : ST_DROP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      data_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule
